multicycle_control_fsm: RTL and testbench

- Moore-style sequencer for the multi-cycle MIPS datapath variant.
- Shares one unified memory, one ALU and the register file across the steps of each instruction: fetch, decode, execute, memory, writeback.
- Supports R-type, lw, sw, beq, j and addi.
- Waits on a variable-latency memory ready handshake, with a bounded wait.

---
 rtl/mips_ctrl_pkg.sv | 138 +++++++++++++
 rtl/multicycle_control_fsm_if.sv | 40 ++++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/multicycle_control_fsm.sv | 117 +++++++++++
 tb/tb_multicycle_control_fsm.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, mux selects,
// the sequencer state set and the per-state control word decode.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    R_WB,
    EXEC_I,
    I_WB,
    MEM_ADDR,
    MEM_RD,
    LW_WB,
    MEM_WR,
    BRANCH,
    JUMP,
    FAULT
  } fsmState_t;

  // Pure state-decoded (Moore) part of the control word; the mem_ready/opCode
  // qualified strobes are added on top of this in the sequencer.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       fault;
  } ctrlWord_t;

  function automatic logic isLegalOp(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic isWaitState(fsmState_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

  function automatic ctrlWord_t ctrlFor(fsmState_t s);
    ctrlWord_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead  = 1'b1;
        c.iorD     = 1'b0;
        c.aluSrcA  = 1'b0;
        c.aluSrcB  = ALUSRCB_FOUR;
        c.aluOp    = ALUOP_ADD;
        c.pcSource = PCSRC_ALU;
      end
      DECODE: begin
        c.aluSrcA = 1'b0;
        c.aluSrcB = ALUSRCB_IMM_SH2;
        c.aluOp   = ALUOP_ADD;
      end
      EXEC_R: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = ALUSRCB_RT;
        c.aluOp   = ALUOP_FUNCT;
      end
      R_WB: begin
        c.regDst    = 1'b1;
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = ALUSRCB_IMM;
        c.aluOp   = ALUOP_ADD;
      end
      I_WB: begin
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      MEM_RD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      LW_WB: begin
        c.memToReg  = 1'b1;
        c.regWrite  = 1'b1;
        c.instrDone = 1'b1;
      end
      MEM_WR: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluSrcB     = ALUSRCB_RT;
        c.aluOp       = ALUOP_SUB;
        c.pcSource    = PCSRC_ALUOUT;
        c.pcWriteCond = 1'b1;
        c.instrDone   = 1'b1;
      end
      JUMP: begin
        c.pcSource  = PCSRC_JUMP;
        c.pcWrite   = 1'b1;
        c.instrDone = 1'b1;
      end
      FAULT: c.fault = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if;

  logic       run;
  logic [5:0] opCode;
  logic       zero;
  logic       mem_ready;

  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] pcSource;
  logic       instr_done;
  logic       illegal_op;
  logic       fault;

  modport master (
    input  run, opCode, zero, mem_ready,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           instr_done, illegal_op, fault
  );

  modport slave (
    output run, opCode, zero, mem_ready,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSource,
           instr_done, illegal_op, fault
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts idle cycles of a pending memory access; expired flags the cycle whose
// miss would bring the count up to limit.
module mem_wait_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          tick,
  input  logic [TW-1:0] limit,
  output logic          expired
);

  logic [TW-1:0] count;
  logic [TW:0]   countNext;

  // One extra bit so the compare cannot wrap when limit sits at the top of the range.
  assign countNext = {1'b0, count} + {{TW{1'b0}}, 1'b1};
  assign expired   = tick && (countNext >= {1'b0, limit});

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= countNext[TW-1:0];
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback
// with a bounded wait on the memory ready handshake and a sticky timeout fault.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master ctrl
);

  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(MEM_TIMEOUT);

  fsmState_t state;
  fsmState_t stateNext;
  ctrlWord_t ctrlQ;

  logic inWait;
  logic waitTick;
  logic waitClear;
  logic waitExpired;
  logic fetchDone;
  logic storeDone;
  logic unusedZero;

  // zero is consumed by the datapath through pcWriteCond, not by the sequencer.
  assign unusedZero = ctrl.zero;

  assign inWait    = isWaitState(state);
  assign waitTick  = inWait && !ctrl.mem_ready;
  assign waitClear = !rst_n || !inWait || (stateNext != state);

  mem_wait_timer #(
    .TW(TW)
  ) uWaitTimer (
    .clk    (clk),
    .clear  (waitClear),
    .tick   (waitTick),
    .limit  (TIMEOUT_LIMIT),
    .expired(waitExpired)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (ctrl.run) stateNext = FETCH;
      FETCH: begin
        if (ctrl.mem_ready)   stateNext = DECODE;
        else if (waitExpired) stateNext = FAULT;
      end
      DECODE: begin
        case (ctrl.opCode)
          OP_RTYPE:     stateNext = EXEC_R;
          OP_LW, OP_SW: stateNext = MEM_ADDR;
          OP_ADDI:      stateNext = EXEC_I;
          OP_BEQ:       stateNext = BRANCH;
          OP_J:         stateNext = JUMP;
          default:      stateNext = FETCH;
        endcase
      end
      EXEC_R:   stateNext = R_WB;
      R_WB:     stateNext = FETCH;
      EXEC_I:   stateNext = I_WB;
      I_WB:     stateNext = FETCH;
      MEM_ADDR: stateNext = (ctrl.opCode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (ctrl.mem_ready)   stateNext = LW_WB;
        else if (waitExpired) stateNext = FAULT;
      end
      LW_WB:    stateNext = FETCH;
      MEM_WR: begin
        if (ctrl.mem_ready)   stateNext = FETCH;
        else if (waitExpired) stateNext = FAULT;
      end
      BRANCH:   stateNext = FETCH;
      JUMP:     stateNext = FETCH;
      FAULT:    stateNext = FAULT;
      default:  stateNext = IDLE;
    endcase
  end

  // Control word is decoded from the next state so every Moore output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ctrlQ <= '0;
    end else begin
      state <= stateNext;
      ctrlQ <= ctrlFor(stateNext);
    end
  end

  // Strobes that fire only on the cycle the memory completes, or on a bad opcode.
  assign fetchDone = (state == FETCH) && ctrl.mem_ready;
  assign storeDone = (state == MEM_WR) && ctrl.mem_ready;

  assign ctrl.irWrite     = fetchDone;
  assign ctrl.pcWrite     = ctrlQ.pcWrite || fetchDone;
  assign ctrl.instr_done  = ctrlQ.instrDone || storeDone;
  assign ctrl.illegal_op  = (state == DECODE) && !isLegalOp(ctrl.opCode);

  assign ctrl.pcWriteCond = ctrlQ.pcWriteCond;
  assign ctrl.iorD        = ctrlQ.iorD;
  assign ctrl.memRead     = ctrlQ.memRead;
  assign ctrl.memWrite    = ctrlQ.memWrite;
  assign ctrl.regDst      = ctrlQ.regDst;
  assign ctrl.memToReg    = ctrlQ.memToReg;
  assign ctrl.regWrite    = ctrlQ.regWrite;
  assign ctrl.aluSrcA     = ctrlQ.aluSrcA;
  assign ctrl.aluSrcB     = ctrlQ.aluSrcB;
  assign ctrl.aluOp       = ctrlQ.aluOp;
  assign ctrl.pcSource    = ctrlQ.pcSource;
  assign ctrl.fault       = ctrlQ.fault;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a step-queue instruction model checked every
// cycle, plus hand-computed expectations on the main instruction flows.
module tb_multicycle_control_fsm;

  localparam int MEM_TIMEOUT = 4;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BAD  = 6'd63;

  // Instruction steps used by the model.
  localparam int ST_FETCH  = 0;
  localparam int ST_DEC    = 1;
  localparam int ST_ALU_R  = 2;
  localparam int ST_WB_R   = 3;
  localparam int ST_ALU_I  = 4;
  localparam int ST_WB_I   = 5;
  localparam int ST_ADDR   = 6;
  localparam int ST_RD     = 7;
  localparam int ST_WB_LW  = 8;
  localparam int ST_WR     = 9;
  localparam int ST_BR     = 10;
  localparam int ST_JMP    = 11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegalOp;
    logic       fault;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus)
  );

  int checks = 0;
  int errors = 0;
  outs_t snap;

  bit modelOn = 1'b0;
  bit mIdle = 1'b1;
  bit mFault = 1'b0;
  int mWait = 0;
  int steps[$];

  function automatic outs_t sampleDut();
    outs_t o;
    o.pcWrite     = bus.pcWrite;
    o.pcWriteCond = bus.pcWriteCond;
    o.iorD        = bus.iorD;
    o.memRead     = bus.memRead;
    o.memWrite    = bus.memWrite;
    o.irWrite     = bus.irWrite;
    o.regDst      = bus.regDst;
    o.memToReg    = bus.memToReg;
    o.regWrite    = bus.regWrite;
    o.aluSrcA     = bus.aluSrcA;
    o.aluSrcB     = bus.aluSrcB;
    o.aluOp       = bus.aluOp;
    o.pcSource    = bus.pcSource;
    o.instrDone   = bus.instr_done;
    o.illegalOp   = bus.illegal_op;
    o.fault       = bus.fault;
    return o;
  endfunction

  function automatic bit legalOp(logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  task automatic expectLit(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // What the clock edge does to the model, given the inputs held across it.
  task automatic modelAdvance();
    int cur;
    if (!rst_n) begin
      modelOn = 1'b1;
      mIdle   = 1'b1;
      mFault  = 1'b0;
      mWait   = 0;
      steps.delete();
    end else if (modelOn && !mFault) begin
      if (mIdle) begin
        if (bus.run) begin
          mIdle = 1'b0;
          mWait = 0;
          steps.push_back(ST_FETCH);
        end
      end else begin
        cur = steps[0];
        if (cur == ST_FETCH || cur == ST_RD || cur == ST_WR) begin
          if (bus.mem_ready) begin
            void'(steps.pop_front());
            mWait = 0;
            if (cur == ST_FETCH) steps.push_back(ST_DEC);
          end else begin
            mWait++;
            if (mWait >= MEM_TIMEOUT) begin
              mFault = 1'b1;
              steps.delete();
            end
          end
        end else if (cur == ST_DEC) begin
          void'(steps.pop_front());
          case (bus.opCode)
            OP_R:    begin steps.push_back(ST_ALU_R); steps.push_back(ST_WB_R); end
            OP_ADDI: begin steps.push_back(ST_ALU_I); steps.push_back(ST_WB_I); end
            OP_LW:   begin steps.push_back(ST_ADDR); steps.push_back(ST_RD); steps.push_back(ST_WB_LW); end
            OP_SW:   begin steps.push_back(ST_ADDR); steps.push_back(ST_WR); end
            OP_BEQ:  steps.push_back(ST_BR);
            OP_J:    steps.push_back(ST_JMP);
            default: ;
          endcase
        end else begin
          void'(steps.pop_front());
        end
        if (!mFault && steps.size() == 0) steps.push_back(ST_FETCH);
      end
    end
  endtask

  initial begin
    outs_t e;
    outs_t a;
    int cur;
    forever begin
      @(negedge clk);
      if (modelOn) begin
        e = '0;
        e.fault = mFault;
        cur = (mIdle || mFault || steps.size() == 0) ? -1 : steps[0];
        case (cur)
          ST_FETCH: begin
            e.memRead = 1'b1; e.aluSrcB = 2'b01;
            e.irWrite = bus.mem_ready; e.pcWrite = bus.mem_ready;
          end
          ST_DEC:   begin e.aluSrcB = 2'b11; e.illegalOp = !legalOp(bus.opCode); end
          ST_ALU_R: begin e.aluSrcA = 1'b1; e.aluOp = 2'b10; end
          ST_WB_R:  begin e.regDst = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1; end
          ST_ALU_I: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
          ST_WB_I:  begin e.regWrite = 1'b1; e.instrDone = 1'b1; end
          ST_ADDR:  begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
          ST_RD:    begin e.memRead = 1'b1; e.iorD = 1'b1; end
          ST_WB_LW: begin e.memToReg = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1; end
          ST_WR:    begin e.memWrite = 1'b1; e.iorD = 1'b1; e.instrDone = bus.mem_ready; end
          ST_BR: begin
            e.aluSrcA = 1'b1; e.aluOp = 2'b01; e.pcSource = 2'b01;
            e.pcWriteCond = 1'b1; e.instrDone = 1'b1;
          end
          ST_JMP:   begin e.pcSource = 2'b10; e.pcWrite = 1'b1; e.instrDone = 1'b1; end
          default: ;
        endcase
        a = sampleDut();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_compare t=%0t step=%0d actual=%h required=%h", $time, cur, a, e);
        end
      end
      modelAdvance();
    end
  end

  task automatic tick(input logic r, input logic [5:0] op, input logic z, input logic rdy);
    bus.run       = r;
    bus.opCode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    @(negedge clk);
    snap = sampleDut();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick(1'b0, OP_R, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int doneAt, cntA, cntB, cntC, firstAt, valAt;
    bit lwRdy[8];
    bit swRdy[8];
    lwRdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    swRdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.run = 1'b0; bus.opCode = OP_R; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and IDLE hold without run.
    tick(1'b0, OP_R, 1'b0, 1'b1);
    expectLit("reset_outputs_zero", int'(snap), 0);
    rst_n = 1'b1;
    tick(1'b0, OP_R, 1'b0, 1'b1);
    tick(1'b0, OP_R, 1'b0, 1'b1);
    expectLit("idle_holds_without_run", int'(snap), 0);

    // R-type with memory always ready.
    doReset();
    tick(1'b1, OP_R, 1'b0, 1'b1);
    doneAt = 0; cntA = 0; valAt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, OP_R, 1'b0, 1'b1);
      if (snap.instrDone && doneAt == 0) doneAt = i;
      cntA += int'(snap.regWrite);
      if (snap.regWrite && snap.regDst) valAt = i;
      if (i == 1) expectLit("r_fetch_alusrcb", int'(snap.aluSrcB), 1);
    end
    expectLit("r_instr_done_cycle", doneAt, 4);
    expectLit("r_regwrite_count", cntA, 1);
    expectLit("r_regdst_cycle", valAt, 4);
    expectLit("r_refetch_irwrite", int'(snap.irWrite), 1);

    // lw with three not-ready cycles; ready arrives on the cycle the limit would be hit.
    doReset();
    tick(1'b1, OP_LW, 1'b0, 1'b1);
    cntA = 0; firstAt = -1; valAt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, OP_LW, 1'b0, lwRdy[i-1]);
      if (snap.memRead && snap.iorD) cntA++;
      if (snap.regWrite && firstAt < 0) begin
        firstAt = i;
        valAt = int'(snap.memToReg);
      end
    end
    expectLit("lw_memread_iord_cycles", cntA, 4);
    expectLit("lw_first_regwrite_cycle", firstAt, 8);
    expectLit("lw_wb_memtoreg", valAt, 1);
    expectLit("lw_ready_at_limit_no_fault", int'(snap.fault), 0);

    // sw then beq with zero=1.
    doReset();
    tick(1'b1, OP_SW, 1'b1, 1'b1);
    cntA = 0; cntB = 0; cntC = 0; doneAt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, (i < 6) ? OP_SW : OP_BEQ, 1'b1, swRdy[i-1]);
      cntA += int'(snap.memWrite);
      cntB += int'(snap.instrDone);
      cntC += int'(snap.regWrite);
      if (snap.instrDone && doneAt == 0) doneAt = i;
    end
    expectLit("sw_memwrite_cycles", cntA, 2);
    expectLit("sw_beq_instr_done_count", cntB, 2);
    expectLit("sw_done_cycle", doneAt, 5);
    expectLit("sw_beq_no_regwrite", cntC, 0);
    expectLit("beq_pcwritecond", int'(snap.pcWriteCond), 1);
    expectLit("beq_pcsource", int'(snap.pcSource), 1);
    expectLit("beq_aluop", int'(snap.aluOp), 1);

    // Unsupported opcode.
    doReset();
    tick(1'b1, OP_BAD, 1'b0, 1'b1);
    cntA = 0; cntB = 0; cntC = 0; firstAt = -1;
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, OP_BAD, 1'b0, 1'b1);
      cntA += int'(snap.illegalOp);
      cntB += int'(snap.instrDone);
      cntC += int'(snap.regWrite) + int'(snap.memWrite);
      if (snap.illegalOp && firstAt < 0) firstAt = i;
    end
    expectLit("illegal_pulse_count", cntA, 1);
    expectLit("illegal_pulse_cycle", firstAt, 2);
    expectLit("illegal_no_instr_done", cntB, 0);
    expectLit("illegal_no_writes", cntC, 0);
    expectLit("illegal_refetch", int'(snap.memRead && !snap.iorD && snap.irWrite), 1);

    // addi then j.
    doReset();
    tick(1'b1, OP_ADDI, 1'b0, 1'b1);
    cntA = 0; cntB = 0; valAt = -1;
    for (int i = 1; i <= 7; i++) begin
      tick(1'b0, (i < 5) ? OP_ADDI : OP_J, 1'b0, 1'b1);
      cntA += int'(snap.instrDone);
      cntB += int'(snap.regWrite);
      if (snap.regWrite) valAt = int'(snap.regDst);
    end
    expectLit("addi_j_instr_done_count", cntA, 2);
    expectLit("addi_regwrite_count", cntB, 1);
    expectLit("addi_regdst_rt", valAt, 0);
    expectLit("j_pcsource", int'(snap.pcSource), 2);
    expectLit("j_pcwrite", int'(snap.pcWrite), 1);

    // Fetch timeout, sticky fault, recovery by reset.
    doReset();
    tick(1'b1, OP_R, 1'b0, 1'b0);
    firstAt = -1; cntA = 0;
    for (int i = 1; i <= 7; i++) begin
      tick(1'b1, OP_R, 1'b0, (i <= 4) ? 1'b0 : 1'b1);
      if (snap.fault && firstAt < 0) firstAt = i;
      if (snap.fault)
        cntA += int'(snap.regWrite) + int'(snap.memWrite) + int'(snap.pcWrite) +
                int'(snap.irWrite) + int'(snap.memRead);
    end
    expectLit("timeout_fault_cycle", firstAt, 5);
    expectLit("fault_strobes_zero", cntA, 0);
    expectLit("fault_sticky", int'(snap.fault), 1);
    rst_n = 1'b0;
    tick(1'b1, OP_R, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick(1'b0, OP_R, 1'b0, 1'b1);
    expectLit("fault_cleared_by_reset", int'(snap), 0);

    // Reset in the middle of a store wait.
    doReset();
    tick(1'b1, OP_SW, 1'b0, 1'b1);
    tick(1'b0, OP_SW, 1'b0, 1'b1);
    tick(1'b0, OP_SW, 1'b0, 1'b1);
    tick(1'b0, OP_SW, 1'b0, 1'b1);
    tick(1'b0, OP_SW, 1'b0, 1'b0);
    expectLit("memwr_before_reset", int'(snap.memWrite), 1);
    rst_n = 1'b0;
    tick(1'b0, OP_SW, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, OP_SW, 1'b0, 1'b0);
    expectLit("memwr_reset_memwrite", int'(snap.memWrite), 0);
    expectLit("memwr_reset_idle", int'(snap), 0);
    tick(1'b1, OP_R, 1'b0, 1'b0);
    firstAt = -1;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, OP_R, 1'b0, 1'b0);
      if (snap.fault && firstAt < 0) firstAt = i;
    end
    expectLit("wait_count_restarts", firstAt, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
